// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and decoded-instruction record for the
// decode stage of the 16-bit CPU.
package cpu_pkg;

    localparam logic [3:0] OP_JMP   = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hD;
    localparam logic [3:0] MODE_IMM = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IMM,
        EMIT,
        REDIR
    } decode_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  opcode;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [3:0]  mode;
        logic        imm_valid;
        logic [15:0] imm;
    } dec_inst_t;

    // A word whose mode selects an immediate, or any JMP, is followed by its immediate.
    function automatic logic is_two_word(input logic [15:0] inst);
        return (inst[3:0] == MODE_IMM) || (inst[15:12] == OP_JMP);
    endfunction

    function automatic dec_inst_t split_word(input logic [15:0] addr, input logic [15:0] inst);
        dec_inst_t d;
        d.addr      = addr;
        d.opcode    = inst[15:12];
        d.dst       = inst[11:8];
        d.src       = inst[7:4];
        d.mode      = inst[3:0];
        d.imm_valid = 1'b0;
        d.imm       = 16'h0000;
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch<->decode and decode<->execute signal bundles. Signal names are seen
// from the decode stage, so _i/_o read as decode inputs/outputs.
interface decode_fe_if;
    logic        fe_valid_i;
    logic        fe_ready_o;
    logic [15:0] fe_addr_i;
    logic [15:0] fe_inst_i;
    logic        fe_pc_valid_o;
    logic [15:0] fe_pc_o;

    modport master (
        output fe_valid_i, fe_addr_i, fe_inst_i,
        input  fe_ready_o, fe_pc_valid_o, fe_pc_o
    );
    modport slave (
        input  fe_valid_i, fe_addr_i, fe_inst_i,
        output fe_ready_o, fe_pc_valid_o, fe_pc_o
    );
endinterface

interface decode_ex_if;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [15:0] ex_addr_o;
    logic [3:0]  ex_opcode_o;
    logic [3:0]  ex_dst_o;
    logic [3:0]  ex_src_o;
    logic [3:0]  ex_mode_o;
    logic        ex_imm_valid_o;
    logic [15:0] ex_imm_o;
    logic        ex_pc_valid_i;
    logic [15:0] ex_pc_i;

    modport master (
        output ex_valid_o, ex_addr_o, ex_opcode_o, ex_dst_o, ex_src_o, ex_mode_o,
               ex_imm_valid_o, ex_imm_o,
        input  ex_ready_i, ex_pc_valid_i, ex_pc_i
    );
    modport slave (
        input  ex_valid_o, ex_addr_o, ex_opcode_o, ex_dst_o, ex_src_o, ex_mode_o,
               ex_imm_valid_o, ex_imm_o,
        output ex_ready_i, ex_pc_valid_i, ex_pc_i
    );
endinterface

// File: rtl/decode_skid.sv
// One-entry skid buffer: passes data straight through when empty and parks one
// beat when the consumer stalls. in_ready_o comes straight from a flop.
module decode_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = ~full_q;
    assign out_valid_o = full_q | in_valid_i;
    assign out_data_o  = full_q ? data_q : in_data_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (!full_q) begin
            if (in_valid_i && !out_ready_i) begin
                full_d = 1'b1;
                data_d = in_data_i;
            end
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: assembles one/two-word instructions, resolves JMP locally and
// issues fetch redirects. Build with DECODE_TRAP_EN to trap opcode 4'hD.
module decode_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] G_RESET_PC = 16'h0000,
    parameter logic [15:0] G_TRAP_PC  = 16'h0010
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    decode_fe_if.slave  fe,
    decode_ex_if.master ex
);
    decode_state_t state_q, state_d;
    dec_inst_t     part_q, part_d, out_q, out_d, word, load_inst;
    logic          out_valid_q, out_valid_d;
    logic          pc_valid_q, pc_valid_d;
    logic [15:0]   pc_q, pc_d;
    logic          drop_q;
    logic          skid_in_valid, sk_valid, sk_ready;
    logic [31:0]   sk_data;
    logic          is_ill, out_free, load, redir, flush;
    logic [15:0]   redir_tgt;

    // Words handshaked during an execute redirect or the cycle after any flush are discarded.
    assign skid_in_valid = fe.fe_valid_i & ~(ex.ex_pc_valid_i | drop_q);

    decode_skid #(.W(32)) u_skid (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (flush),
        .in_valid_i  (skid_in_valid),
        .in_ready_o  (fe.fe_ready_o),
        .in_data_i   ({fe.fe_addr_i, fe.fe_inst_i}),
        .out_valid_o (sk_valid),
        .out_ready_i (sk_ready),
        .out_data_o  (sk_data)
    );

    assign word     = split_word(sk_data[31:16], sk_data[15:0]);
    assign out_free = ~out_valid_q | ex.ex_ready_i;

`ifdef DECODE_TRAP_EN
    assign is_ill = (word.opcode == OP_ILL);
`else
    assign is_ill = 1'b0;
`endif

    // Next state; a word goes straight to the output register when the slot is free,
    // EMIT only holds it while execute is still busy.
    always_comb begin
        state_d   = state_q;
        part_d    = part_q;
        sk_ready  = 1'b0;
        load      = 1'b0;
        load_inst = part_q;
        redir     = 1'b0;
        redir_tgt = G_TRAP_PC;
        case (state_q)
            IDLE: begin
                sk_ready = 1'b1;
                if (sk_valid) begin
                    if (is_ill) begin
                        redir     = 1'b1;
                        redir_tgt = G_TRAP_PC;
                        state_d   = REDIR;
                    end else if (is_two_word(sk_data[15:0])) begin
                        part_d  = word;
                        state_d = WAIT_IMM;
                    end else if (out_free) begin
                        load      = 1'b1;
                        load_inst = word;
                    end else begin
                        part_d  = word;
                        state_d = EMIT;
                    end
                end
            end
            WAIT_IMM: begin
                sk_ready = 1'b1;
                if (sk_valid) begin
                    load_inst.imm_valid = 1'b1;
                    load_inst.imm       = sk_data[15:0];
                    if (part_q.opcode == OP_JMP) begin
                        redir     = 1'b1;
                        redir_tgt = sk_data[15:0];
                        state_d   = REDIR;
                    end else if (out_free) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        part_d  = load_inst;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_free) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            REDIR: begin
                sk_ready = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Execute redirect wins over anything decode resolved this cycle.
        if (ex.ex_pc_valid_i) begin
            state_d = IDLE;
            load    = 1'b0;
        end
        if (flush) begin
            part_d = '0;
        end
    end

    assign flush = ex.ex_pc_valid_i | redir;

    always_comb begin
        out_valid_d = out_valid_q & ~ex.ex_ready_i;
        out_d       = out_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_d       = load_inst;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
        pc_valid_d = flush;
        pc_d       = pc_q;
        if (ex.ex_pc_valid_i) begin
            pc_d = ex.ex_pc_i;
        end else if (redir) begin
            pc_d = redir_tgt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            part_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pc_valid_q  <= 1'b1;
            pc_q        <= G_RESET_PC;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            part_q      <= part_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            pc_valid_q  <= pc_valid_d;
            pc_q        <= pc_d;
            drop_q      <= flush;
        end
    end

    assign fe.fe_pc_valid_o  = pc_valid_q;
    assign fe.fe_pc_o        = pc_q;
    assign ex.ex_valid_o     = out_valid_q;
    assign ex.ex_addr_o      = out_q.addr;
    assign ex.ex_opcode_o    = out_q.opcode;
    assign ex.ex_dst_o       = out_q.dst;
    assign ex.ex_src_o       = out_q.src;
    assign ex.ex_mode_o      = out_q.mode;
    assign ex.ex_imm_valid_o = out_q.imm_valid;
    assign ex.ex_imm_o       = out_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; inputs change 1 time unit
// after the rising edge and outputs are read there too.
module tb_decode_stage;
    logic clk;
    logic rstn;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic [31:0] xfers[$];

    decode_fe_if fe_bus ();
    decode_ex_if ex_bus ();

    decode_stage dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .fe     (fe_bus),
        .ex     (ex_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every execute-side transfer; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rstn && ex_bus.ex_valid_o && ex_bus.ex_ready_i)
            xfers.push_back({ex_bus.ex_addr_o, ex_bus.ex_opcode_o, ex_bus.ex_dst_o,
                             ex_bus.ex_src_o, ex_bus.ex_mode_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] addr, input logic [15:0] inst);
        fe_bus.fe_valid_i = 1'b1;
        fe_bus.fe_addr_i  = addr;
        fe_bus.fe_inst_i  = inst;
    endtask

    task automatic test_reset();
        tick(); tick();
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b1) $display("FAIL rst_pc_valid: got %0b want 1", fe_bus.fe_pc_valid_o); else pass_cnt++;
        chk_cnt++; if (fe_bus.fe_pc_o !== 16'h0000) $display("FAIL rst_pc: got %h want 0000", fe_bus.fe_pc_o); else pass_cnt++;
        chk_cnt++; if (fe_bus.fe_ready_o !== 1'b1) $display("FAIL rst_ready: got %0b want 1", fe_bus.fe_ready_o); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b0) $display("FAIL rst_ex_valid: got %0b want 0", ex_bus.ex_valid_o); else pass_cnt++;
        chk_cnt++; if ({ex_bus.ex_addr_o, ex_bus.ex_opcode_o, ex_bus.ex_imm_valid_o, ex_bus.ex_imm_o} !== 37'h0)
            $display("FAIL rst_ex_fields: got %h want 0", {ex_bus.ex_addr_o, ex_bus.ex_opcode_o, ex_bus.ex_imm_valid_o, ex_bus.ex_imm_o}); else pass_cnt++;
        rstn = 1'b1;
        #1;
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b1) $display("FAIL rel_pc_valid: got %0b want 1", fe_bus.fe_pc_valid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b0) $display("FAIL rel_pc_fall: got %0b want 0", fe_bus.fe_pc_valid_o); else pass_cnt++;
        chk_cnt++; if (fe_bus.fe_ready_o !== 1'b1) $display("FAIL rel_ready: got %0b want 1", fe_bus.fe_ready_o); else pass_cnt++;
    endtask

    task automatic test_single();
        xfers.delete();
        put(16'h0000, 16'h1230);
        tick();
        fe_bus.fe_valid_i = 1'b0;
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b1) $display("FAIL single_valid: got %0b want 1", ex_bus.ex_valid_o); else pass_cnt++;
        chk_cnt++; if ({ex_bus.ex_opcode_o, ex_bus.ex_dst_o, ex_bus.ex_src_o, ex_bus.ex_mode_o} !== 16'h1230)
            $display("FAIL single_fields: got %h want 1230", {ex_bus.ex_opcode_o, ex_bus.ex_dst_o, ex_bus.ex_src_o, ex_bus.ex_mode_o}); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_imm_valid_o !== 1'b0) $display("FAIL single_immv: got %0b want 0", ex_bus.ex_imm_valid_o); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_addr_o !== 16'h0000) $display("FAIL single_addr: got %h want 0000", ex_bus.ex_addr_o); else pass_cnt++;
        tick();
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b0) $display("FAIL single_drain: got %0b want 0", ex_bus.ex_valid_o); else pass_cnt++;
        chk_cnt++; if (xfers.size() !== 1) $display("FAIL single_count: got %0d want 1", xfers.size()); else pass_cnt++;
    endtask

    task automatic test_two_word();
        xfers.delete();
        put(16'h0010, 16'h412F);
        tick();
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b0) $display("FAIL two_early: got %0b want 0", ex_bus.ex_valid_o); else pass_cnt++;
        put(16'h0011, 16'hBEEF);
        tick();
        fe_bus.fe_valid_i = 1'b0;
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b1) $display("FAIL two_valid: got %0b want 1", ex_bus.ex_valid_o); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_imm_valid_o !== 1'b1) $display("FAIL two_immv: got %0b want 1", ex_bus.ex_imm_valid_o); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_imm_o !== 16'hBEEF) $display("FAIL two_imm: got %h want beef", ex_bus.ex_imm_o); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_addr_o !== 16'h0010) $display("FAIL two_addr: got %h want 0010", ex_bus.ex_addr_o); else pass_cnt++;
        chk_cnt++; if ({ex_bus.ex_opcode_o, ex_bus.ex_dst_o, ex_bus.ex_src_o, ex_bus.ex_mode_o} !== 16'h412F)
            $display("FAIL two_fields: got %h want 412f", {ex_bus.ex_opcode_o, ex_bus.ex_dst_o, ex_bus.ex_src_o, ex_bus.ex_mode_o}); else pass_cnt++;
        tick();
        chk_cnt++; if (xfers.size() !== 1) $display("FAIL two_count: got %0d want 1", xfers.size()); else pass_cnt++;
    endtask

    task automatic test_jmp();
        xfers.delete();
        put(16'h0020, 16'hE00F);
        tick();
        put(16'h0021, 16'h0100);
        tick();
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b1) $display("FAIL jmp_pulse: got %0b want 1", fe_bus.fe_pc_valid_o); else pass_cnt++;
        chk_cnt++; if (fe_bus.fe_pc_o !== 16'h0100) $display("FAIL jmp_target: got %h want 0100", fe_bus.fe_pc_o); else pass_cnt++;
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b0) $display("FAIL jmp_no_ex: got %0b want 0", ex_bus.ex_valid_o); else pass_cnt++;
        chk_cnt++; if (fe_bus.fe_ready_o !== 1'b1) $display("FAIL jmp_ready: got %0b want 1", fe_bus.fe_ready_o); else pass_cnt++;
        put(16'h0022, 16'h1110);
        tick();
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b0) $display("FAIL jmp_pulse_end: got %0b want 0", fe_bus.fe_pc_valid_o); else pass_cnt++;
        put(16'h0100, 16'h2340);
        tick();
        fe_bus.fe_valid_i = 1'b0;
        chk_cnt++; if ({ex_bus.ex_valid_o, ex_bus.ex_addr_o, ex_bus.ex_opcode_o} !== {1'b1, 16'h0100, 4'h2})
            $display("FAIL jmp_next: got %b/%h/%h want 1/0100/2", ex_bus.ex_valid_o, ex_bus.ex_addr_o, ex_bus.ex_opcode_o); else pass_cnt++;
        tick();
        chk_cnt++; if (xfers.size() !== 1) $display("FAIL jmp_count: got %0d want 1", xfers.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int idx   = 0;
        int stall = 0;
        xfers.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc >= 2 && cyc <= 4) begin
                chk_cnt++; if ({ex_bus.ex_valid_o, ex_bus.ex_addr_o, ex_bus.ex_opcode_o} !== {1'b1, 16'h0030, 4'h1})
                    $display("FAIL b2b_hold%0d: got %b/%h/%h want 1/0030/1", cyc, ex_bus.ex_valid_o, ex_bus.ex_addr_o, ex_bus.ex_opcode_o); else pass_cnt++;
            end
            if (cyc == 3) begin
                chk_cnt++; if (fe_bus.fe_ready_o !== 1'b0) $display("FAIL b2b_ready_low: got %0b want 0", fe_bus.fe_ready_o); else pass_cnt++;
            end
            ex_bus.ex_ready_i = !(cyc >= 1 && cyc <= 3);
            if (idx < 5) begin
                put(16'h0030 + 16'(idx), {4'(idx + 1), 12'h000});
                if (fe_bus.fe_ready_o) idx++;
                else stall++;
            end else begin
                fe_bus.fe_valid_i = 1'b0;
            end
            tick();
        end
        chk_cnt++; if (idx !== 5) $display("FAIL b2b_accepted: got %0d want 5", idx); else pass_cnt++;
        chk_cnt++; if (stall > 4) $display("FAIL b2b_stall: got %0d want <=4", stall); else pass_cnt++;
        chk_cnt++; if (xfers.size() !== 5) $display("FAIL b2b_count: got %0d want 5", xfers.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (i < xfers.size()) begin
                chk_cnt++; if (xfers[i] !== {16'h0030 + 16'(i), 4'(i + 1), 12'h000})
                    $display("FAIL b2b_order%0d: got %h want %h", i, xfers[i], {16'h0030 + 16'(i), 4'(i + 1), 12'h000}); else pass_cnt++;
            end
        end
    endtask

    task automatic test_ex_redirect();
        xfers.delete();
        put(16'h0040, 16'hE00F);
        tick();
        put(16'h0041, 16'h0100);
        ex_bus.ex_pc_valid_i = 1'b1;
        ex_bus.ex_pc_i       = 16'h0200;
        tick();
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b1) $display("FAIL exr_pulse: got %0b want 1", fe_bus.fe_pc_valid_o); else pass_cnt++;
        chk_cnt++; if (fe_bus.fe_pc_o !== 16'h0200) $display("FAIL exr_target: got %h want 0200", fe_bus.fe_pc_o); else pass_cnt++;
        ex_bus.ex_pc_valid_i = 1'b0;
        put(16'h0042, 16'h5550);
        tick();
        chk_cnt++; if ({fe_bus.fe_pc_valid_o, ex_bus.ex_valid_o} !== 2'b00)
            $display("FAIL exr_quiet: got %b want 00", {fe_bus.fe_pc_valid_o, ex_bus.ex_valid_o}); else pass_cnt++;
        put(16'h0200, 16'h3450);
        tick();
        fe_bus.fe_valid_i = 1'b0;
        chk_cnt++; if ({ex_bus.ex_valid_o, ex_bus.ex_addr_o, ex_bus.ex_opcode_o, ex_bus.ex_imm_valid_o} !== {1'b1, 16'h0200, 4'h3, 1'b0})
            $display("FAIL exr_next: got %b/%h/%h/%b want 1/0200/3/0", ex_bus.ex_valid_o, ex_bus.ex_addr_o, ex_bus.ex_opcode_o, ex_bus.ex_imm_valid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (fe_bus.fe_pc_valid_o !== 1'b0) $display("FAIL exr_no_jmp: got %0b want 0", fe_bus.fe_pc_valid_o); else pass_cnt++;
        chk_cnt++; if (xfers.size() !== 1) $display("FAIL exr_count: got %0d want 1", xfers.size()); else pass_cnt++;
    endtask

    task automatic test_flush_handshake();
        xfers.delete();
        put(16'h0050, 16'h6780);
        tick();
        fe_bus.fe_valid_i    = 1'b0;
        ex_bus.ex_ready_i    = 1'b0;
        ex_bus.ex_pc_valid_i = 1'b1;
        ex_bus.ex_pc_i       = 16'h0300;
        tick();
        chk_cnt++; if ({ex_bus.ex_valid_o, fe_bus.fe_pc_valid_o, fe_bus.fe_pc_o} !== {2'b01, 16'h0300})
            $display("FAIL fl_kill: got %b/%b/%h want 0/1/0300", ex_bus.ex_valid_o, fe_bus.fe_pc_valid_o, fe_bus.fe_pc_o); else pass_cnt++;
        ex_bus.ex_pc_valid_i = 1'b0;
        ex_bus.ex_ready_i    = 1'b1;
        tick();
        put(16'h0300, 16'h6790);
        tick();
        fe_bus.fe_valid_i    = 1'b0;
        ex_bus.ex_pc_valid_i = 1'b1;
        ex_bus.ex_pc_i       = 16'h0400;
        tick();
        ex_bus.ex_pc_valid_i = 1'b0;
        chk_cnt++; if ({ex_bus.ex_valid_o, fe_bus.fe_pc_o} !== {1'b0, 16'h0400})
            $display("FAIL fl_redirect: got %b/%h want 0/0400", ex_bus.ex_valid_o, fe_bus.fe_pc_o); else pass_cnt++;
        chk_cnt++; if (xfers.size() !== 1) $display("FAIL fl_count: got %0d want 1", xfers.size()); else pass_cnt++;
        if (xfers.size() > 0) begin
            chk_cnt++; if (xfers[0][31:16] !== 16'h0300) $display("FAIL fl_addr: got %h want 0300", xfers[0][31:16]); else pass_cnt++;
        end
        tick();
    endtask

    task automatic test_illegal();
        put(16'h0060, 16'hD000);
        tick();
        fe_bus.fe_valid_i = 1'b0;
`ifdef DECODE_TRAP_EN
        chk_cnt++; if ({ex_bus.ex_valid_o, fe_bus.fe_pc_valid_o, fe_bus.fe_pc_o} !== {2'b01, 16'h0010})
            $display("FAIL trap: got %b/%b/%h want 0/1/0010", ex_bus.ex_valid_o, fe_bus.fe_pc_valid_o, fe_bus.fe_pc_o); else pass_cnt++;
        tick();
        chk_cnt++; if ({ex_bus.ex_valid_o, fe_bus.fe_pc_valid_o} !== 2'b00)
            $display("FAIL trap_end: got %b want 00", {ex_bus.ex_valid_o, fe_bus.fe_pc_valid_o}); else pass_cnt++;
`else
        chk_cnt++; if ({ex_bus.ex_valid_o, ex_bus.ex_opcode_o, fe_bus.fe_pc_valid_o} !== {1'b1, 4'hD, 1'b0})
            $display("FAIL op_d: got %b/%h/%b want 1/d/0", ex_bus.ex_valid_o, ex_bus.ex_opcode_o, fe_bus.fe_pc_valid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (ex_bus.ex_valid_o !== 1'b0) $display("FAIL op_d_drain: got %0b want 0", ex_bus.ex_valid_o); else pass_cnt++;
`endif
    endtask

    initial begin
        rstn                 = 1'b0;
        fe_bus.fe_valid_i    = 1'b0;
        fe_bus.fe_addr_i     = 16'h0000;
        fe_bus.fe_inst_i     = 16'h0000;
        ex_bus.ex_ready_i    = 1'b1;
        ex_bus.ex_pc_valid_i = 1'b0;
        ex_bus.ex_pc_i       = 16'h0000;
        test_reset();
        test_single();
        test_two_word();
        test_jmp();
        test_back_to_back();
        test_ex_redirect();
        test_flush_handshake();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
